writeback_regfile: RTL and testbench
====================================

# writeback_regfile

Writeback-stage consumer of the MEM/WB pipeline register in the pipelined MIPS core. Selects the writeback result from the W-stage control bits (`RegWriteW`, `MemtoRegW`), commits it to a 32-entry general-purpose register file, and serves the two decode-stage read ports. Also keeps a free-running count of committed register writes for debug and performance observation.

## Interface
Parameters:
- `DATA_W`, default 32: register and datapath width.
- `ADDR_W`, default 5: register index width; the file holds 2^ADDR_W entries.
- `CNT_W`, default 32: width of the commit counter.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `RegWriteW`  in  1  W-stage register write enable.
- `MemtoRegW`  in  1  W-stage result select: 1 selects load data, 0 selects ALU result.
- `ReadDataW`  in  DATA_W  load data from MEM/WB.
- `ALUOutW`  in  DATA_W  ALU result from MEM/WB.
- `WriteRegW`  in  ADDR_W  destination register index.
- `A1`  in  ADDR_W  decode read port 1 index (rs).
- `A2`  in  ADDR_W  decode read port 2 index (rt).
- `RD1`  out  DATA_W  read port 1 data.
- `RD2`  out  DATA_W  read port 2 data.
- `ResultW`  out  DATA_W  selected writeback value; also feeds the forwarding muxes.
- `CommitCount`  out  CNT_W  number of committed register writes.

## Operation
- `ResultW` is combinational: `MemtoRegW ? ReadDataW : ALUOutW`.
- Commit condition: `RegWriteW && WriteRegW != 0`.
- On a rising edge with the commit condition true, the register at `WriteRegW` takes `ResultW`.
- Register 0 is hardwired to 0:
  - A write to index 0 is discarded and does not increment `CommitCount`.
  - A read of index 0 returns 0 in every mode.
- Reads are combinational from the array: `RD1 = R[A1]` and `RD2 = R[A2]`, subject to the bypass rule in Configuration.
- `CommitCount` increments by 1 on each edge where the commit condition holds. It wraps modulo 2^CNT_W with no saturation and no flag.
- `A1 == A2` is legal; both ports return the same value.
- No other state; the block has no internal FSM.

## Timing
- Reset asserted: every register reads 0, `CommitCount` = 0, and `RD1`/`RD2` = 0 for any address.
  - Reset applies immediately, independent of `clk`.
  - A write pending at the same edge as reset release is lost.
- Write latency: a value presented in cycle N is stored at the end-of-cycle-N edge.
  - With the macro defined, it is readable in cycle N through the bypass.
  - Without the macro, it is readable from cycle N+1.
- `ResultW` has zero-cycle latency from its inputs.
- `CommitCount` reflects a commit from the edge that performs the write.
- Reset asserted mid-stream clears everything; the first write after release behaves normally.

## Configuration
- Macro: `WB_BYPASS_EN`.
- Defined: write-first internal bypass. When the commit condition holds and `WriteRegW == A1`, `RD1 = ResultW` in the same cycle; the same rule applies to `A2`/`RD2`. The hazard unit then needs no W-to-D forwarding path.
- Not defined: reads always return the stored array value. A same-cycle read of the register being written returns the old value, and the hazard unit must stall or forward for that case.
- Bypass never applies to index 0.

## Test plan
- Reset state: assert `reset`, sweep `A1`/`A2` over 0..31 -> `RD1`/`RD2` = 0 at every index; `CommitCount` = 0.
- Load versus ALU select:
  - `RegWriteW=1`, `WriteRegW=5`, `MemtoRegW=1`, `ReadDataW=0xDEADBEEF`, `ALUOutW=0x1234` -> `ResultW` = 0xDEADBEEF, `R5` = 0xDEADBEEF next cycle.
  - Repeat with `MemtoRegW=0` -> `R5` = 0x1234.
- Register 0 protection: write 0xFFFFFFFF to index 0 -> `RD1` with `A1=0` stays 0; `CommitCount` unchanged.
- Same-cycle read of the write target: `A1=7`, write 0xA5A5A5A5 to index 7 in that cycle.
  - With `WB_BYPASS_EN` -> `RD1` = 0xA5A5A5A5 in the same cycle.
  - Without it -> old value in the same cycle, new value the next cycle.
- Counter wrap: `CNT_W=4`, perform 17 commits to indices 1..17 -> `CommitCount` = 1.
- Asynchronous reset mid-stream: `R3` = 0x55, assert `reset` between clock edges -> `RD1` (`A1=3`) = 0 immediately and `CommitCount` = 0 before the next edge.

Source files
------------

// File: rtl/writeback_regfile_if.sv
// Writeback/regfile bundle: W-stage result inputs, decode read ports, commit count.
// Latency: none, signal bundle only.
// Backpressure: none; the pipeline drives it every cycle.
interface writeback_regfile_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
);
  logic              RegWriteW;
  logic              MemtoRegW;
  logic [DATA_W-1:0] ReadDataW;
  logic [DATA_W-1:0] ALUOutW;
  logic [ADDR_W-1:0] WriteRegW;
  logic [ADDR_W-1:0] A1;
  logic [ADDR_W-1:0] A2;
  logic [DATA_W-1:0] RD1;
  logic [DATA_W-1:0] RD2;
  logic [DATA_W-1:0] ResultW;
  logic [CNT_W-1:0]  CommitCount;

  // Pipeline / decode side: drives the W-stage bits and read addresses.
  modport master (
    output RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WriteRegW, A1, A2,
    input  RD1, RD2, ResultW, CommitCount
  );

  // Register file side.
  modport slave (
    input  RegWriteW, MemtoRegW, ReadDataW, ALUOutW, WriteRegW, A1, A2,
    output RD1, RD2, ResultW, CommitCount
  );
endinterface

// File: rtl/writeback_regfile.sv
// Writeback result select, 2^ADDR_W-entry register file (R0 = 0), commit counter.
// Latency: ResultW/reads combinational; write stored at the edge; WB_BYPASS_EN gives same-cycle read.
// Backpressure: none; every commit is accepted on the edge it is presented.
module writeback_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic                clk,
  input  logic                reset,
  writeback_regfile_if.slave  wb
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [CNT_W-1:0]  commit_cnt_q;
  logic [CNT_W-1:0]  commit_cnt_d;
  logic [DATA_W-1:0] result;
  logic              commit;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;

  // Writeback value select and commit qualification (R0 writes never commit).
  always_comb begin
    result = wb.MemtoRegW ? wb.ReadDataW : wb.ALUOutW;
    commit = wb.RegWriteW && (wb.WriteRegW != '0);
  end

  // Next state of the array and the commit counter.
  always_comb begin
    for (int i = 0; i < NREG; i++) regs_d[i] = regs_q[i];
    commit_cnt_d = commit_cnt_q;
    if (commit) begin
      regs_d[wb.WriteRegW] = result;
      commit_cnt_d         = commit_cnt_q + CNT_W'(1);
    end
    regs_d[0] = '0;
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      commit_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
      commit_cnt_q <= commit_cnt_d;
    end
  end

  // Decode read ports; the optional bypass is write-first and never hits R0
  // because commit already excludes index 0.
  always_comb begin
    rd1 = (wb.A1 == '0) ? '0 : regs_q[wb.A1];
    rd2 = (wb.A2 == '0) ? '0 : regs_q[wb.A2];
`ifdef WB_BYPASS_EN
    if (commit && (wb.WriteRegW == wb.A1)) rd1 = result;
    if (commit && (wb.WriteRegW == wb.A2)) rd2 = result;
`endif
  end

  assign wb.RD1         = rd1;
  assign wb.RD2         = rd2;
  assign wb.ResultW     = result;
  assign wb.CommitCount = commit_cnt_q;

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile (CNT_W=4 so the counter wrap is reachable).
// Inputs change on the falling edge, outputs sampled before the next change.
// Works with or without WB_BYPASS_EN defined.
module tb_writeback_regfile;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  writeback_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) wb_if ();

  writeback_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .wb    (wb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic m2r, input logic [31:0] rdat,
                       input logic [31:0] alu, input logic [4:0] wr);
    wb_if.RegWriteW = we;
    wb_if.MemtoRegW = m2r;
    wb_if.ReadDataW = rdat;
    wb_if.ALUOutW   = alu;
    wb_if.WriteRegW = wr;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    wb_if.A1 = 5'd0;
    wb_if.A2 = 5'd0;

    // Reset state: every index reads 0, counter 0.
    #2;
    for (int a = 0; a < 32; a++) begin
      wb_if.A1 = 5'(a);
      wb_if.A2 = 5'(31 - a);
      #1;
      check("reset_rd1", wb_if.RD1, 32'h0);
      check("reset_rd2", wb_if.RD2, 32'h0);
    end
    check("reset_cnt", 32'(wb_if.CommitCount), 32'h0);

    @(negedge clk);
    reset = 1'b0;

    // Load select into R5.
    @(negedge clk);
    drive(1'b1, 1'b1, 32'hDEADBEEF, 32'h0000_1234, 5'd5);
    wb_if.A1 = 5'd5;
    wb_if.A2 = 5'd0;
    #1;
    check("load_resultw", wb_if.ResultW, 32'hDEADBEEF);
    check("load_same_cycle_rd1", wb_if.RD1, BYP ? 32'hDEADBEEF : 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    check("load_r5", wb_if.RD1, 32'hDEADBEEF);
    check("load_cnt", 32'(wb_if.CommitCount), 32'd1);

    // ALU select into R5.
    @(negedge clk);
    drive(1'b1, 1'b0, 32'hDEADBEEF, 32'h0000_1234, 5'd5);
    #1;
    check("alu_resultw", wb_if.ResultW, 32'h0000_1234);
    @(negedge clk);
    drive(1'b0, 1'b1, 32'hCAFE_0000, 32'h0, 5'd5);
    #1;
    check("idle_resultw", wb_if.ResultW, 32'hCAFE_0000);
    check("alu_r5", wb_if.RD1, 32'h0000_1234);
    check("alu_cnt", 32'(wb_if.CommitCount), 32'd2);

    // Register 0 protection, including no bypass on index 0.
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFF, 5'd0);
    wb_if.A1 = 5'd0;
    wb_if.A2 = 5'd0;
    #1;
    check("r0_same_cycle_rd1", wb_if.RD1, 32'h0);
    check("r0_same_cycle_rd2", wb_if.RD2, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    check("r0_after_rd1", wb_if.RD1, 32'h0);
    check("r0_cnt", 32'(wb_if.CommitCount), 32'd2);

    // Same-cycle read of the write target (R7 old = 0x11111111).
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, 32'h1111_1111, 5'd7);
    @(negedge clk);
    drive(1'b1, 1'b1, 32'hA5A5_A5A5, 32'h0, 5'd7);
    wb_if.A1 = 5'd7;
    wb_if.A2 = 5'd7;
    #1;
    check("r7_same_cycle_rd1", wb_if.RD1, BYP ? 32'hA5A5_A5A5 : 32'h1111_1111);
    check("r7_same_cycle_rd2", wb_if.RD2, BYP ? 32'hA5A5_A5A5 : 32'h1111_1111);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    #1;
    check("r7_next_rd1", wb_if.RD1, 32'hA5A5_A5A5);
    check("r7_next_rd2", wb_if.RD2, 32'hA5A5_A5A5);
    check("r7_cnt", 32'(wb_if.CommitCount), 32'd4);

    // Independent ports; a write to another index does not disturb them.
    wb_if.A1 = 5'd5;
    wb_if.A2 = 5'd7;
    drive(1'b1, 1'b0, 32'h0, 32'h0000_0055, 5'd3);
    #1;
    check("port_rd1_r5", wb_if.RD1, 32'h0000_1234);
    check("port_rd2_r7", wb_if.RD2, 32'hA5A5_A5A5);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    wb_if.A1 = 5'd3;
    #1;
    check("r3_value", wb_if.RD1, 32'h0000_0055);
    check("r3_cnt", 32'(wb_if.CommitCount), 32'd5);

    // Asynchronous reset between edges.
    #1;
    reset = 1'b1;
    #1;
    check("async_rd1_r3", wb_if.RD1, 32'h0);
    check("async_rd2_r7", wb_if.RD2, 32'h0);
    check("async_cnt", 32'(wb_if.CommitCount), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Counter wrap: 17 commits to indices 1..17 with a 4-bit counter.
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b0, 32'h0, 32'(i * 3), 5'(i));
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    wb_if.A1 = 5'd17;
    wb_if.A2 = 5'd1;
    #1;
    check("wrap_cnt", 32'(wb_if.CommitCount), 32'd1);
    check("wrap_r17", wb_if.RD1, 32'd51);
    check("wrap_r1", wb_if.RD2, 32'd3);
    wb_if.A1 = 5'd5;
    #1;
    check("post_reset_r5", wb_if.RD1, 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
